// File: rtl/fnd_scan_ctrl_if.sv
// Signal bundle between the FND scan controller and its surroundings
// (digit mux feedback, mask registers, display pins).
interface fnd_scan_ctrl_if;
  logic       enable;
  logic [3:0] bcd;
  logic [7:0] blink_mask;
  logic [7:0] dp_mask;
  logic [2:0] sel;
  logic [7:0] fnd_com;
  logic       fnd_dp;
  logic       frame_tick;

  modport master (
    output enable, bcd, blink_mask, dp_mask,
    input  sel, fnd_com, fnd_dp, frame_tick
  );

  modport slave (
    input  enable, bcd, blink_mask, dp_mask,
    output sel, fnd_com, fnd_dp, frame_tick
  );
endinterface

// File: rtl/fnd_scan_ctrl.sv
// Multiplexed 7-segment scan controller: slot timing with anti-ghost gap, blink and DP masks.
// Optional leading-zero blanking is built when FND_LZB_EN is defined.
module fnd_scan_ctrl #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned SCAN_HZ    = 1_000,
  parameter int unsigned GAP_CYC    = 2,
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned BLINK_HZ   = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  fnd_scan_ctrl_if.slave fnd
);

  localparam int unsigned DIGIT_CYC  = CLK_HZ / SCAN_HZ;
  localparam int unsigned BLINK_HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int unsigned ND         = (NUM_DIGITS == 4) ? 4 : 8;
  localparam int unsigned CNT_W      = (DIGIT_CYC > 2) ? $clog2(DIGIT_CYC) : 1;
  localparam int unsigned BLK_W      = (BLINK_HALF > 2) ? $clog2(BLINK_HALF) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_HALF - 1);
  localparam logic [2:0]       SEL_LAST = 3'(ND - 1);

  typedef enum logic {
    ST_GAP,
    ST_SHOW
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_sel;
  logic [BLK_W-1:0] r_blk_cnt;
  logic             r_blink_phase;
  logic [7:0]       r_com;
  logic             r_dp;
  logic             r_tick;

  logic w_slot_wrap;
  logic w_sel_last;
  logic w_frame_wrap;
  logic w_lz_blank_sel;
  logic w_blank;

  assign w_slot_wrap  = (r_cnt == CNT_LAST);
  assign w_sel_last   = (r_sel == SEL_LAST);
  assign w_frame_wrap = w_slot_wrap & w_sel_last;

`ifdef FND_LZB_EN
  logic [7:0] r_zacc;
  logic [7:0] r_zflag;
  logic [7:0] w_zacc_next;
  logic [7:0] w_lz_blank;

  // Flags gathered over one frame are committed at the frame wrap, so blanking lags a frame.
  always_comb begin
    w_zacc_next = r_zacc;
    if (r_state == ST_SHOW) w_zacc_next[r_sel] = (fnd.bcd == 4'd0);
    for (int unsigned i = 0; i < 8; i++) begin
      w_lz_blank[i] = (i != 0);
      for (int unsigned j = 0; j < 8; j++) begin
        if (j >= i && j < ND) w_lz_blank[i] = w_lz_blank[i] & r_zflag[j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_zacc  <= '0;
      r_zflag <= '0;
    end else if (fnd.enable) begin
      r_zacc <= w_zacc_next;
      if (w_frame_wrap) r_zflag <= w_zacc_next;
    end
  end

  assign w_lz_blank_sel = w_lz_blank[r_sel];
`else
  logic w_unused_bcd;
  assign w_unused_bcd   = ^fnd.bcd;
  assign w_lz_blank_sel = 1'b0;
`endif

  assign w_blank = (r_blink_phase & fnd.blink_mask[r_sel]) | w_lz_blank_sel;

  // Outputs are computed from the pre-edge cnt/sel, so commons trail sel by one cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= ST_GAP;
      r_cnt         <= '0;
      r_sel         <= '0;
      r_blk_cnt     <= '0;
      r_blink_phase <= 1'b0;
      r_com         <= '1;
      r_dp          <= 1'b1;
      r_tick        <= 1'b0;
    end else if (!fnd.enable) begin
      r_com  <= '1;
      r_dp   <= 1'b1;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_frame_wrap;

      if (w_slot_wrap) begin
        r_cnt <= '0;
        r_sel <= w_sel_last ? 3'd0 : r_sel + 3'd1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      case (r_state)
        ST_GAP:  if (r_cnt == GAP_LAST) r_state <= ST_SHOW;
        ST_SHOW: if (w_slot_wrap) r_state <= ST_GAP;
        default: r_state <= ST_GAP;
      endcase

      if (r_blk_cnt == BLK_LAST) begin
        r_blk_cnt     <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blk_cnt <= r_blk_cnt + 1'b1;
      end

      if (r_state == ST_SHOW && !w_blank) begin
        r_com <= ~(8'd1 << r_sel);
        r_dp  <= ~fnd.dp_mask[r_sel];
      end else begin
        r_com <= '1;
        r_dp  <= 1'b1;
      end
    end
  end

  assign fnd.sel        = r_sel;
  assign fnd.fnd_com    = r_com;
  assign fnd.fnd_dp     = r_dp;
  assign fnd.frame_tick = r_tick;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Bench for fnd_scan_ctrl: 4- and 8-digit instances checked against a time-index model.
`timescale 1ns/1ps
module tb_fnd_scan_ctrl;
  localparam int unsigned DC = 10;
  localparam int unsigned BH = 50;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic       en = 1'b0;
  logic [7:0] bm = '0;
  logic [7:0] dm = '0;
  logic [3:0] digits [8];

  int unsigned errors = 0;
  int unsigned checks = 0;

  fnd_scan_ctrl_if bus4 ();
  fnd_scan_ctrl_if bus8 ();

  assign bus4.enable     = en;
  assign bus4.blink_mask = bm;
  assign bus4.dp_mask    = dm;
  assign bus4.bcd        = digits[bus4.sel];
  assign bus8.enable     = en;
  assign bus8.blink_mask = bm;
  assign bus8.dp_mask    = dm;
  assign bus8.bcd        = digits[bus8.sel];

  fnd_scan_ctrl #(.CLK_HZ(1000), .SCAN_HZ(100), .GAP_CYC(2), .NUM_DIGITS(4), .BLINK_HZ(10))
    dut4 (.clk(clk), .reset_n(reset_n), .fnd(bus4));
  fnd_scan_ctrl #(.CLK_HZ(1000), .SCAN_HZ(100), .GAP_CYC(2), .NUM_DIGITS(8), .BLINK_HZ(10))
    dut8 (.clk(clk), .reset_n(reset_n), .fnd(bus8));

  // {sel[2:0], fnd_com[7:0], fnd_dp, frame_tick}
  logic [12:0] obs  [2];
  logic [12:0] expv [2];
  assign obs[0] = {bus4.sel, bus4.fnd_com, bus4.fnd_dp, bus4.frame_tick};
  assign obs[1] = {bus8.sel, bus8.fnd_com, bus8.fnd_dp, bus8.frame_tick};

  int unsigned nd_of [2] = '{4, 8};
  int unsigned t     [2] = '{0, 0};
  logic [7:0]  m_com;
  logic        m_dp;

  // Outputs from t enabled cycles since reset: slot = t/DC, position in slot = t%DC, blink phase = t/BH.
  function automatic void model_out(input int unsigned tt, input int unsigned n,
                                    input logic [7:0] bmk, input logic [7:0] dmk,
                                    output logic [7:0] com, output logic dp);
    int unsigned c, s;
    logic blank;
    c = tt % DC;
    s = (tt / DC) % n;
    blank = (((tt / BH) % 2) == 1) && bmk[s];
`ifdef FND_LZB_EN
    if (s > 0 && (tt / (DC * n)) >= 1) begin
      logic lz;
      lz = 1'b1;
      for (int unsigned j = s; j < n; j++) if (digits[j] != 4'd0) lz = 1'b0;
      blank = blank | lz;
    end
`endif
    com = 8'hFF;
    dp  = 1'b1;
    if (c >= 2 && !blank) begin
      com[s] = 1'b0;
      dp     = ~dmk[s];
    end
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset_n) begin
        t[k]    = 0;
        expv[k] = {3'd0, 8'hFF, 1'b1, 1'b0};
      end else if (!en) begin
        expv[k] = {expv[k][12:10], 8'hFF, 1'b1, 1'b0};
      end else begin
        model_out(t[k], nd_of[k], bm, dm, m_com, m_dp);
        t[k]    = t[k] + 1;
        expv[k] = {3'((t[k] / DC) % nd_of[k]), m_com, m_dp, ((t[k] % (DC * nd_of[k])) == 0)};
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    en = 1'b1; bm = 8'hFF; dm = 8'hFF;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== {3'd0, 8'hFF, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL reset_vals dut%0d got=%h exp=%h", nd_of[k], obs[k], {3'd0, 8'hFF, 1'b1, 1'b0});
      end
    end
    reset_n = 1'b1;
  endtask

  task automatic test_scan();
    int unsigned last [2];
    int unsigned nticks [2];
    logic [2:0] prev_sel [2];
    do_reset();
    en = 1'b1; bm = '0; dm = '0;
    last = '{0, 0}; nticks = '{0, 0}; prev_sel = '{3'd0, 3'd0};
    for (int unsigned cyc = 1; cyc <= 240; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== expv[k]) begin
          errors++;
          $display("FAIL scan dut%0d cyc=%0d got=%h exp=%h", nd_of[k], cyc, obs[k], expv[k]);
        end
        if (obs[k][0] === 1'b1) begin
          nticks[k]++;
          if (last[k] != 0) begin
            checks++;
            if (cyc - last[k] != DC * nd_of[k]) begin
              errors++;
              $display("FAIL tick_period dut%0d got=%0d exp=%0d", nd_of[k], cyc - last[k], DC * nd_of[k]);
            end
          end
          last[k] = cyc;
        end
        if (obs[k][12:10] !== prev_sel[k]) begin
          checks++;
          if (obs[k][2 + obs[k][12:10]] !== 1'b1) begin
            errors++;
            $display("FAIL com_on_sel_change dut%0d cyc=%0d got=%h exp_bit=1", nd_of[k], cyc, obs[k][9:2]);
          end
        end
        prev_sel[k] = obs[k][12:10];
      end
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (nticks[k] != 240 / (DC * nd_of[k])) begin
        errors++;
        $display("FAIL tick_count dut%0d got=%0d exp=%0d", nd_of[k], nticks[k], 240 / (DC * nd_of[k]));
      end
    end
  endtask

  task automatic test_blink();
    do_reset();
    en = 1'b1; bm = 8'h02; dm = '0;
    for (int unsigned cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== expv[k]) begin
          errors++;
          $display("FAIL blink dut%0d cyc=%0d got=%h exp=%h", nd_of[k], cyc, obs[k], expv[k]);
        end
      end
    end
  endtask

  task automatic test_dp();
    int unsigned dp_low;
    do_reset();
    en = 1'b1; bm = '0; dm = 8'h04;
    dp_low = 0;
    for (int unsigned cyc = 1; cyc <= 80; cyc++) begin
      @(negedge clk);
      if (bus4.fnd_dp === 1'b0) dp_low++;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== expv[k]) begin
          errors++;
          $display("FAIL dp dut%0d cyc=%0d got=%h exp=%h", nd_of[k], cyc, obs[k], expv[k]);
        end
      end
    end
    checks++;
    if (dp_low != 16) begin
      errors++;
      $display("FAIL dp_low_count got=%0d exp=16", dp_low);
    end
  endtask

  task automatic test_enable_hold();
    int unsigned n;
    do_reset();
    en = 1'b1; bm = '0; dm = '0;
    repeat (15) @(negedge clk);
    en = 1'b0;
    for (int unsigned cyc = 1; cyc <= 15; cyc++) begin
      @(negedge clk);
      checks++;
      if (obs[0][12:2] !== {3'd1, 8'hFF} || obs[0][0] !== 1'b0) begin
        errors++;
        $display("FAIL hold_frozen cyc=%0d got=%h exp_sel=1 exp_com=ff", cyc, obs[0]);
      end
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== expv[k]) begin
          errors++;
          $display("FAIL hold dut%0d cyc=%0d got=%h exp=%h", nd_of[k], cyc, obs[k], expv[k]);
        end
      end
    end
    en = 1'b1;
    n = 0;
    for (int unsigned cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      n = cyc;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== expv[k]) begin
          errors++;
          $display("FAIL resume dut%0d cyc=%0d got=%h exp=%h", nd_of[k], cyc, obs[k], expv[k]);
        end
      end
      if (bus4.sel !== 3'd1) break;
    end
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL resume_remaining got=%0d exp=5", n);
    end
  endtask

  task automatic test_random();
    do_reset();
    en = 1'b1; bm = 8'($urandom); dm = 8'($urandom);
    for (int unsigned cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== expv[k]) begin
          errors++;
          $display("FAIL random dut%0d cyc=%0d got=%h exp=%h", nd_of[k], cyc, obs[k], expv[k]);
        end
      end
      if ($urandom_range(0, 7) == 0) bm = 8'($urandom);
      if ($urandom_range(0, 7) == 0) dm = 8'($urandom);
      en = ($urandom_range(0, 9) != 0);
    end
  endtask

`ifdef FND_LZB_EN
  task automatic test_lzb();
    int unsigned lit0, lit1;
    for (int i = 0; i < 8; i++) digits[i] = 4'd0;
    digits[1] = 4'd5;
    do_reset();
    en = 1'b1; bm = '0; dm = '0;
    lit0 = 0; lit1 = 0;
    for (int unsigned cyc = 1; cyc <= 240; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== expv[k]) begin
          errors++;
          $display("FAIL lzb dut%0d cyc=%0d got=%h exp=%h", nd_of[k], cyc, obs[k], expv[k]);
        end
      end
      if (cyc > 42) begin
        checks++;
        if (bus4.fnd_com[3:2] !== 2'b11) begin
          errors++;
          $display("FAIL lzb_dark cyc=%0d got=%h exp_bits32=11", cyc, bus4.fnd_com);
        end
        if (bus4.fnd_com[0] === 1'b0) lit0++;
        if (bus4.fnd_com[1] === 1'b0) lit1++;
      end
    end
    checks++;
    if (lit0 == 0 || lit1 == 0) begin
      errors++;
      $display("FAIL lzb_lit got=%0d,%0d exp=nonzero", lit0, lit1);
    end
    for (int i = 0; i < 8; i++) digits[i] = 4'(i + 1);
  endtask
`endif

  task automatic test_reset_midframe();
    do_reset();
    en = 1'b1; bm = 8'h0F; dm = 8'hA5;
    repeat (25) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== {3'd0, 8'hFF, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL reset_midframe dut%0d got=%h exp=%h", nd_of[k], obs[k], {3'd0, 8'hFF, 1'b1, 1'b0});
      end
    end
    reset_n = 1'b1;
    repeat (30) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== expv[k]) begin
        errors++;
        $display("FAIL after_reset dut%0d got=%h exp=%h", nd_of[k], obs[k], expv[k]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) digits[i] = 4'(i + 1);
    test_reset();
    test_scan();
    test_blink();
    test_dp();
    test_enable_hold();
    test_random();
`ifdef FND_LZB_EN
    test_lzb();
`endif
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
